// File: rtl/demux_burst_writer.sv
// demux_burst_writer: bursts of words demuxed into 16 registered outputs starting at a base index.
// Optional DEMUX_BURST_STROBE_EN adds a one-hot wr_strobe marking freshly written outputs.
module demux_burst_writer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        base,
  input  logic [3:0]        len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [DATA_W-1:0] out8,
  output logic [DATA_W-1:0] out9,
  output logic [DATA_W-1:0] out10,
  output logic [DATA_W-1:0] out11,
  output logic [DATA_W-1:0] out12,
  output logic [DATA_W-1:0] out13,
  output logic [DATA_W-1:0] out14,
  output logic [DATA_W-1:0] out15
`ifdef DEMUX_BURST_STROBE_EN
  ,
  output logic [15:0]       wr_strobe
`endif
);
  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] ptr_q, ptr_d, rem_q, rem_d;
  logic [DATA_W-1:0] mem_q [16];
  logic in_ready_q, busy_q, done_q, xfer, load;
  assign xfer = in_valid && state_q == BURST;
  assign load = start && state_q == IDLE;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    state_d = state_q == IDLE  ? (start ? BURST : IDLE) :
              state_q == BURST ? ((xfer && rem_q == 4'd0) ? DONE : BURST) : IDLE;
    ptr_d   = load ? base : xfer ? ptr_q + 4'd1 : ptr_q;
    rem_d   = load ? len : (xfer && rem_q != 4'd0) ? rem_q - 4'd1 : rem_q;
  end
  // flags are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      in_ready_q <= state_d == BURST;
      busy_q     <= state_d != IDLE;
      done_q     <= state_d == DONE;
      if (xfer) mem_q[ptr_q] <= in_data;
    end
  end
`ifdef DEMUX_BURST_STROBE_EN
  logic [15:0] strobe_q;
  always_ff @(posedge clk) begin
    if (rst) strobe_q <= '0;
    else     strobe_q <= xfer ? 16'(1) << ptr_q : 16'd0;
  end
  assign wr_strobe = strobe_q;
`endif
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign out0  = mem_q[0];
  assign out1  = mem_q[1];
  assign out2  = mem_q[2];
  assign out3  = mem_q[3];
  assign out4  = mem_q[4];
  assign out5  = mem_q[5];
  assign out6  = mem_q[6];
  assign out7  = mem_q[7];
  assign out8  = mem_q[8];
  assign out9  = mem_q[9];
  assign out10 = mem_q[10];
  assign out11 = mem_q[11];
  assign out12 = mem_q[12];
  assign out13 = mem_q[13];
  assign out14 = mem_q[14];
  assign out15 = mem_q[15];
endmodule

// File: doc/demux_burst_writer.md
DEMUX_BURST_WRITER -- requirements
Module: demux_burst_writer

Interface
REQ-001 SHALL have parameter: DATA_W, 16, width of data input and of each output word.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a burst, sampled in IDLE only.
REQ-005 SHALL have port: base  input  4  first destination index, sampled with start.
REQ-006 SHALL have port: len  input  4  burst length minus one (0 = 1 word, 15 = 16 words), sampled with start.
REQ-007 SHALL have port: in_valid  input  1  in_data holds a word.
REQ-008 SHALL have port: in_data  input  DATA_W  word to store.
REQ-009 SHALL have port: in_ready  output  1  block accepts a word this cycle.
REQ-010 SHALL have port: busy  output  1  high in BURST and DONE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse at burst end.
REQ-012 SHALL have ports: out0..out15  output  DATA_W each  registered destination words.

Function
REQ-013 SHALL implement states IDLE, BURST, DONE; state and all outputs registered.
REQ-014 SHALL, in IDLE with start=1, load ptr=base and remaining=len and enter BURST next cycle.
REQ-015 SHALL hold in_ready=1 only in BURST; in_ready=0 in IDLE and DONE.
REQ-016 SHALL accept a word only when in_valid=1 and in_ready=1 (transfer).
REQ-017 SHALL, on transfer, write in_data into out[ptr], visible the following cycle; all other outN unchanged.
REQ-018 SHALL, on transfer, increment ptr modulo 16 (index 15 wraps to 0).
REQ-019 SHALL, on transfer with remaining=0, enter DONE; otherwise decrement remaining and stay in BURST.
REQ-020 SHALL stay in BURST with no change when in_valid=0 (stalls unbounded).
REQ-021 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-022 SHALL ignore start in BURST and DONE; start in the IDLE cycle right after DONE SHALL be honoured.
REQ-023 SHALL ignore in_valid/in_data outside BURST.
REQ-024 SHALL, for len=15 from any base, write all 16 outputs once each, wrapping as needed.
REQ-025 SHALL retain outN values indefinitely between bursts.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, set state=IDLE, ptr=0, remaining=0, all outN=0, in_ready=0, busy=0, done=0.
REQ-027 SHALL, on reset mid-burst, abort without asserting done; rst SHALL override start and transfers in the same cycle.

Configuration
REQ-028 SHALL, with macro DEMUX_BURST_STROBE_EN defined, add port wr_strobe  output  16  one-hot, bit N high for exactly the cycle outN first shows a newly written value; reset value 0.
REQ-029 SHALL, without DEMUX_BURST_STROBE_EN, omit wr_strobe entirely with all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then start base=2 len=2, words 0x1111,0x2222,0x3333 back-to-back -> out2/out3/out4 = those words, done pulses once on the cycle after third transfer, others 0.
REQ-031 SHALL cover: base=14 len=3, words 0xA0..0xA3 -> out14=0xA0, out15=0xA1, out0=0xA2, out1=0xA3 (wrap).
REQ-032 SHALL cover: base=5 len=1 with in_valid low 4 cycles between words -> in_ready held 1, out5/out6 written, done only after second word.
REQ-033 SHALL cover: start pulsed mid-burst and in_valid=1 in IDLE with 0xDEAD -> no extra burst, no output changes.
REQ-034 SHALL cover: rst asserted after 2 of 4 words -> all outN=0, done never asserted, new burst after rst accepted normally.
REQ-035 SHALL cover (DEMUX_BURST_STROBE_EN): base=7 len=0 word 0x00FF -> wr_strobe=0x0080 for one cycle coincident with out7=0x00FF.
